mem_copy_initiator: RTL
=======================

// Module: mem_copy_initiator
// PURPOSE
//  Bus initiator for the data-memory / peripheral port that the MEM stage answers (MemRead,
//  MemWrite, word Address, WrData, single-cycle combinational read data). Copies LEN words
//  from SRC to DST, one read then one write per word, so RAM or MMIO (0x4000_0000 map) can
//  be filled without CPU loads/stores. Sits beside the pipeline; a bus_req/bus_gnt pair arbitrates the port.
// PARAMETERS
//  ADDR_W   32  address / data width (word = 4 bytes, fixed)
//  LEN_W    16  width of word-count fields
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  start      in   1       1-cycle request; sampled only in IDLE
//  abort      in   1       cancel an in-flight copy
//  src_addr   in   ADDR_W  source byte address, must be word aligned
//  dst_addr   in   ADDR_W  destination byte address, must be word aligned
//  len        in   LEN_W   number of 32-bit words to copy
//  busy       out  1       high from accepted start until return to IDLE
//  done       out  1       1-cycle pulse on successful completion
//  err        out  1       1-cycle pulse: unaligned start or abort
//  words_done out  LEN_W   words fully written in current/last copy
//  bus_req    out  1       request ownership of the memory port
//  bus_gnt    in   1       port granted this cycle
//  MemRead    out  1       read strobe to port
//  MemWrite   out  1       write strobe to port (write commits at clk edge)
//  Address    out  ADDR_W  byte address to port
//  WrData     out  ADDR_W  write data to port
//  ReadData   in   ADDR_W  combinational read data from port (same cycle)
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE; busy, done, err, bus_req, MemRead, MemWrite = 0;
//   Address, WrData, words_done, internal src/dst/remaining/buffer = 0. Bus strobes drop
//   immediately on reset assertion, even mid-copy; no partial write completes.
//  States: IDLE, RD, WR, FIN.
//  IDLE: start=1 and (src_addr|dst_addr)[1:0]!=0 -> err pulse next cycle, stay IDLE.
//   start=1, aligned, len==0 -> FIN (done pulse, no bus activity). start=1, aligned,
//   len!=0 -> latch src/dst/len, words_done<=0, -> RD. start outside IDLE ignored.
//  bus_req = 1 in RD and WR only. Strobes combinational: MemRead=(RD&&bus_gnt),
//   MemWrite=(WR&&bus_gnt); Address=src in RD, dst in WR, 0 otherwise; WrData=buffer in WR.
//  RD: bus_gnt=0 -> hold (stall any number of cycles). bus_gnt=1 -> capture ReadData into
//   buffer at edge, -> WR. Latency 2 granted cycles per word.
//  WR: bus_gnt=0 -> hold. bus_gnt=1 -> write commits; src+=4, dst+=4 (mod 2^ADDR_W, wrap
//   silently), remaining-=1, words_done+=1; remaining was 1 -> FIN else -> RD.
//  FIN: done=1 for exactly one cycle, -> IDLE. busy=1 in RD, WR, FIN.
//  abort=1 in RD/WR: strobes forced 0 that cycle (abort beats bus_gnt), err pulse next
//   cycle, -> IDLE; words_done keeps count of completed writes. abort in IDLE/FIN ignored.
//  start and abort together in IDLE: abort ignored, start processed.
//  Source/destination overlap not checked; copy is strictly ascending word by word.
// STRUCTURE
//  Shared package: state encoding (IDLE/RD/WR/FIN), WORD_BYTES=4, MMIO base 32'h4000_0000
//   and peripheral offsets (TH 0x0, TL 0x4, TCON 0x8, LED 0xC, DIGIT 0x10, SYSTICK 0x14).
//  Single module; no sub-module. Strobe/address mux is a small combinational block on state.
// TESTING
//  RAM model 0x100..0x108 = A,B,C; start src=0x100 dst=0x200 len=3, gnt=1 -> 6 strobe
//   cycles alternating R/W, 0x200..0x208 = A,B,C, done 1 cycle, words_done=3.
//  src=0x100 dst=0x4000000C len=1 into MMIO model -> single MemWrite, LED reg = A[7:0].
//  Same 3-word copy with bus_gnt low 2 of every 3 cycles -> same final RAM, no strobe while
//   gnt=0, bus_req steady high throughout.
//  len=0 -> done next cycle, zero strobes; src=0x102 -> err pulse, zero strobes, busy=0.
//  dst=0xFFFFFFFC len=2 -> second write at Address 0x00000000 (wrap).
//  Abort in WR of word 2 -> no write that cycle, err pulse, words_done=1; reset low mid-RD
//   -> strobes 0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/mem_copy_initiator_pkg.sv
// -----------------------------------------------------------------------------
// mem_copy_initiator_pkg
//   Shared definitions for the memory-copy bus initiator: FSM state encoding,
//   bus word size, default widths, and the MMIO map of the peripheral block
//   that sits behind the data-memory port.
// -----------------------------------------------------------------------------
package mem_copy_initiator_pkg;

  // Default widths of the copy engine.
  localparam int ADDR_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;

  // The port moves whole 32-bit words; addresses step by this many bytes.
  localparam int WORD_BYTES = 4;

  // Memory-mapped peripheral window and register offsets inside it.
  localparam logic [31:0] MMIO_BASE    = 32'h4000_0000;
  localparam logic [31:0] OFF_TH       = 32'h0000_0000;
  localparam logic [31:0] OFF_TL       = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON     = 32'h0000_0008;
  localparam logic [31:0] OFF_LED      = 32'h0000_000C;
  localparam logic [31:0] OFF_DIGIT    = 32'h0000_0010;
  localparam logic [31:0] OFF_SYSTICK  = 32'h0000_0014;

  // Copy-engine states.
  //   ST_IDLE : waiting for start
  //   ST_RD   : reading the current source word (holds until granted)
  //   ST_WR   : writing the buffered word to the destination (holds until granted)
  //   ST_FIN  : one-cycle completion state that raises done
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // True when the OR of the low byte-offset bits of all addresses is zero.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage : mem_copy_initiator_pkg

// File: rtl/mem_copy_initiator.sv
// -----------------------------------------------------------------------------
// mem_copy_initiator
//   Bus initiator on the data-memory / peripheral port. Copies len 32-bit words
//   from src_addr to dst_addr, strictly ascending, one read followed by one
//   write per word. The port is shared with the pipeline: bus_req asks for it
//   and each strobe is only issued in a cycle where bus_gnt is high.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   start      : 1-cycle copy request, only looked at in IDLE
//   abort      : cancels an in-flight copy (RD/WR)
//   src_addr   : source byte address (word aligned)
//   dst_addr   : destination byte address (word aligned)
//   len        : number of words to copy
//   busy       : high in RD, WR and FIN
//   done       : 1-cycle pulse on successful completion (FIN)
//   err        : 1-cycle pulse after an unaligned start or an abort
//   words_done : words fully written in the current / last copy
//   bus_req    : port request, high in RD and WR
//   bus_gnt    : port granted this cycle
//   MemRead    : read strobe
//   MemWrite   : write strobe (write commits at the clock edge)
//   Address    : byte address to the port
//   WrData     : write data to the port
//   ReadData   : combinational read data returned in the same cycle
// -----------------------------------------------------------------------------
module mem_copy_initiator
  import mem_copy_initiator_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [ADDR_W-1:0] WrData,
  input  logic [ADDR_W-1:0] ReadData
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,      state_d;
  logic [ADDR_W-1:0]   src_q,        src_d;
  logic [ADDR_W-1:0]   dst_q,        dst_d;
  logic [LEN_W-1:0]    remaining_q,  remaining_d;
  logic [LEN_W-1:0]    words_done_q, words_done_d;
  logic [ADDR_W-1:0]   buffer_q,     buffer_d;
  logic                err_q,        err_d;

  logic                start_aligned;

  assign start_aligned = is_word_aligned(src_addr[1:0] | dst_addr[1:0]);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given its hold/default value before the case so no
  // path leaves a signal unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    remaining_d  = remaining_q;
    words_done_d = words_done_q;
    buffer_d     = buffer_q;
    err_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort has no meaning here, so start alone decides.
        if (start) begin
          if (!start_aligned) begin
            err_d = 1'b1;
          end else if (len == '0) begin
            words_done_d = '0;
            state_d      = ST_FIN;
          end else begin
            src_d        = src_addr;
            dst_d        = dst_addr;
            remaining_d  = len;
            words_done_d = '0;
            state_d      = ST_RD;
          end
        end
      end

      ST_RD: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bus_gnt) begin
          buffer_d = ReadData;
          state_d  = ST_WR;
        end
      end

      ST_WR: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (bus_gnt) begin
          // Address arithmetic wraps modulo 2^ADDR_W by design.
          src_d        = src_q + ADDR_STEP;
          dst_d        = dst_q + ADDR_STEP;
          remaining_d  = remaining_q - LEN_ONE;
          words_done_d = words_done_q + LEN_ONE;
          state_d      = (remaining_q == LEN_ONE) ? ST_FIN : ST_RD;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      remaining_q  <= '0;
      words_done_q <= '0;
      buffer_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      remaining_q  <= remaining_d;
      words_done_q <= words_done_d;
      buffer_q     <= buffer_d;
      err_q        <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Port strobes and address mux
  //   Decoded straight from the state register, so an asserted reset forces
  //   IDLE and drops every strobe in the same cycle. abort wins over bus_gnt.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_req  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Address  = '0;
    WrData   = '0;

    unique case (state_q)
      ST_RD: begin
        bus_req = 1'b1;
        MemRead = bus_gnt && !abort;
        Address = src_q;
      end
      ST_WR: begin
        bus_req  = 1'b1;
        MemWrite = bus_gnt && !abort;
        Address  = dst_q;
        WrData   = buffer_q;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign err        = err_q;
  assign words_done = words_done_q;

endmodule : mem_copy_initiator
